// File: rtl/mux2_rr_sched.sv
// Round-robin owner of a shared 2:1 mux: registered grants and select, combinational Z/VALID/ACK.
// Bursts are capped at MAX_HOLD transfers only while the other requester waits; handover costs no bubble.
module mux2_rr_sched #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             READY,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             ACK_A,
  output logic             ACK_B,
  output logic             S,
  output logic [WIDTH-1:0] Z,
  output logic             VALID
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic          s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;  // 0: A served last, 1: B served last
  logic          xfer, hold_done;
  logic          go_a, go_b, go_idle;

  assign GNT_A     = (state_q == OWN_A);
  assign GNT_B     = (state_q == OWN_B);
  assign S         = s_q;
  assign Z         = s_q ? B : A;
  assign VALID     = (GNT_A & REQ_A) | (GNT_B & REQ_B);
  assign ACK_A     = GNT_A & REQ_A & READY;
  assign ACK_B     = GNT_B & REQ_B & READY;
  assign xfer      = VALID & READY;
  assign hold_done = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    go_a    = 1'b0;
    go_b    = 1'b0;
    go_idle = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ_A && (!REQ_B || last_q)) go_a = 1'b1;
        else if (REQ_B)                  go_b = 1'b1;
      end
      OWN_A: begin
        if (!REQ_A) begin
          if (REQ_B) go_b = 1'b1;
          else       go_idle = 1'b1;
        end else if (xfer) begin
          if (!hold_done) cnt_d = cnt_q + 1'b1;
          else if (REQ_B) go_b = 1'b1;
          else            cnt_d = '0;   // nobody waiting: restart the burst
        end
      end
      OWN_B: begin
        if (!REQ_B) begin
          if (REQ_A) go_a = 1'b1;
          else       go_idle = 1'b1;
        end else if (xfer) begin
          if (!hold_done) cnt_d = cnt_q + 1'b1;
          else if (REQ_A) go_a = 1'b1;
          else            cnt_d = '0;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_a) begin
      state_d = OWN_A;
      s_d     = 1'b0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else if (go_b) begin
      state_d = OWN_B;
      s_d     = 1'b1;
      cnt_d   = '0;
      last_d  = 1'b1;
    end else if (go_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_sched.sv
// Directed table of per-cycle {inputs, expected outputs} for mux2_rr_sched plus an async mid-burst reset sequence.
module tb_mux2_rr_sched;

  logic       CK, RST, REQ_A, REQ_B, READY;
  logic [7:0] A, B, Z;
  logic       GNT_A, GNT_B, ACK_A, ACK_B, S, VALID;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst, ra, rb;
    logic [7:0] a, b;
    logic       rdy;
    logic       ga, gb, s, v, aa, ab;
    logic [7:0] z;
  } vec_t;

  vec_t tbl[$];

  mux2_rr_sched #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .CK(CK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B), .A(A), .B(B), .READY(READY),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .ACK_A(ACK_A), .ACK_B(ACK_B), .S(S), .Z(Z), .VALID(VALID)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic add(input logic rst, ra, rb, input logic [7:0] a, b, input logic rdy,
                     input logic ga, gb, s, v, aa, ab, input logic [7:0] z);
    vec_t t;
    t.rst = rst; t.ra = ra; t.rb = rb; t.a = a; t.b = b; t.rdy = rdy;
    t.ga = ga; t.gb = gb; t.s = s; t.v = v; t.aa = aa; t.ab = ab; t.z = z;
    tbl.push_back(t);
  endtask

  task automatic cmp(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    RST = t.rst; REQ_A = t.ra; REQ_B = t.rb; A = t.a; B = t.b; READY = t.rdy;
  endtask

  task automatic check_all(input vec_t t, input int row);
    cmp("GNT_A", row, {7'd0, GNT_A}, {7'd0, t.ga});
    cmp("GNT_B", row, {7'd0, GNT_B}, {7'd0, t.gb});
    cmp("S",     row, {7'd0, S},     {7'd0, t.s});
    cmp("VALID", row, {7'd0, VALID}, {7'd0, t.v});
    cmp("ACK_A", row, {7'd0, ACK_A}, {7'd0, t.aa});
    cmp("ACK_B", row, {7'd0, ACK_B}, {7'd0, t.ab});
    cmp("Z",     row, Z,             t.z);
  endtask

  // One table row per clock cycle: inputs change just after the rising edge, outputs checked at the falling edge.
  task automatic run_row(input vec_t t, input int row);
    @(posedge CK);
    #1 drive(t);
    @(negedge CK);
    check_all(t, row);
  endtask

  initial begin
    RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; A = 8'h3C; B = 8'h00; READY = 1'b0;

    //  rst ra rb  a      b      rdy  ga gb s  v  aa ab z
    add(1, 0, 0, 8'h3C, 8'h00, 0,   0, 0, 0, 0, 0, 0, 8'h3C);
    repeat (5) add(0, 0, 0, 8'h3C, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h3C);
    // contention from IDLE with B as last served: A first, 4-beat blocks
    add(0, 1, 1, 8'hAA, 8'h55, 1, 0, 0, 0, 0, 0, 0, 8'hAA);
    repeat (4) add(0, 1, 1, 8'hAA, 8'h55, 1, 1, 0, 0, 1, 1, 0, 8'hAA);
    repeat (4) add(0, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 1, 0, 1, 8'h55);
    repeat (4) add(0, 1, 1, 8'hAA, 8'h55, 1, 1, 0, 0, 1, 1, 0, 8'hAA);
    // backpressure in OWN_B after 2 transfers
    repeat (2) add(0, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 1, 0, 1, 8'h55);
    repeat (3) add(0, 1, 1, 8'hAA, 8'h55, 0, 0, 1, 1, 1, 0, 0, 8'h55);
    repeat (2) add(0, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 1, 0, 1, 8'h55);
    add(0, 1, 1, 8'hAA, 8'h55, 1, 1, 0, 0, 1, 1, 0, 8'hAA);
    // early release with the other side waiting, then with nobody waiting
    add(0, 0, 1, 8'hAA, 8'h55, 1, 1, 0, 0, 0, 0, 0, 8'hAA);
    add(0, 0, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 1, 0, 1, 8'h55);
    add(0, 1, 0, 8'hAA, 8'h55, 1, 0, 1, 1, 0, 0, 0, 8'h55);
    add(0, 1, 0, 8'hAA, 8'h55, 1, 1, 0, 0, 1, 1, 0, 8'hAA);
    add(0, 0, 0, 8'hAA, 8'h55, 1, 1, 0, 0, 0, 0, 0, 8'hAA);
    add(0, 0, 0, 8'hAA, 8'h55, 1, 0, 0, 0, 0, 0, 0, 8'hAA);
    // single requester: 10 back-to-back beats, burst restarts without losing the grant
    add(0, 1, 0, 8'h11, 8'h55, 1, 0, 0, 0, 0, 0, 0, 8'h11);
    repeat (10) add(0, 1, 0, 8'h11, 8'h55, 1, 1, 0, 0, 1, 1, 0, 8'h11);
    add(0, 0, 0, 8'h11, 8'h55, 1, 1, 0, 0, 0, 0, 0, 8'h11);
    add(0, 0, 0, 8'h11, 8'h55, 1, 0, 0, 0, 0, 0, 0, 8'h11);
    // B alone, then S must hold 1 in IDLE
    add(0, 0, 1, 8'h11, 8'h77, 1, 0, 0, 0, 0, 0, 0, 8'h11);
    add(0, 0, 1, 8'h11, 8'h77, 1, 0, 1, 1, 1, 0, 1, 8'h77);
    add(0, 0, 0, 8'h11, 8'h77, 1, 0, 1, 1, 0, 0, 0, 8'h77);
    add(0, 0, 0, 8'h11, 8'h77, 1, 0, 0, 1, 0, 0, 0, 8'h77);
    add(0, 0, 1, 8'h22, 8'h99, 1, 0, 0, 1, 0, 0, 0, 8'h99);

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    // Mid-burst asynchronous reset while OWN_B, with both sides requesting
    @(posedge CK);
    #1 begin REQ_A = 1'b1; REQ_B = 1'b1; READY = 1'b1; end
    #1;
    cmp("pre_rst GNT_B", 1000, {7'd0, GNT_B}, 8'd1);
    cmp("pre_rst VALID", 1000, {7'd0, VALID}, 8'd1);
    cmp("pre_rst Z",     1000, Z,             8'h99);
    #1 RST = 1'b1;
    #1;
    cmp("async_rst GNT_B", 1001, {7'd0, GNT_B}, 8'd0);
    cmp("async_rst S",     1001, {7'd0, S},     8'd0);
    cmp("async_rst VALID", 1001, {7'd0, VALID}, 8'd0);
    cmp("async_rst ACK_B", 1001, {7'd0, ACK_B}, 8'd0);
    cmp("async_rst Z",     1001, Z,             8'h22);
    @(posedge CK);
    #1 RST = 1'b0;
    @(posedge CK);
    #1;
    cmp("post_rst GNT_A", 1002, {7'd0, GNT_A}, 8'd1);
    cmp("post_rst GNT_B", 1002, {7'd0, GNT_B}, 8'd0);
    cmp("post_rst S",     1002, {7'd0, S},     8'd0);
    cmp("post_rst ACK_A", 1002, {7'd0, ACK_A}, 8'd1);
    cmp("post_rst Z",     1002, Z,             8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
